msg_sequencer: RTL and testbench

MSG_SEQUENCER -- requirements
Module: msg_sequencer

---
 rtl/uart_pkg.sv | 26 ++
 rtl/msg_sequencer.sv | 122 ++++++++++++
 tb/tb_msg_sequencer.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the message sequencer: default parameters and FSM state encoding.
// Latency: none (definitions only).
// Backpressure: not applicable.
package uart_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int MAX_LEN_DEF = 32;
    localparam int NUM_MSG_DEF = 4;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_PUSH  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_FETCH = ST_FETCH,
        S_WAIT  = ST_WAIT,
        S_PUSH  = ST_PUSH,
        S_DRAIN = ST_DRAIN,
        S_DONE  = ST_DONE
    } seq_state_e;

endpackage

// File: rtl/msg_sequencer.sv
// Streams a selected message from an external ROM into a TX FIFO, one character at a time.
// Latency: 3 cycles per character (FETCH, WAIT, PUSH) with a non-full FIFO; done follows FIFO drain.
// Backpressure: fifo_full stalls in PUSH without writing; start only accepted on an empty FIFO.
module msg_sequencer
    import uart_pkg::*;
#(
    parameter int                 DATA_W   = DATA_W_DEF,
    parameter int                 MAX_LEN  = MAX_LEN_DEF,
    parameter int                 NUM_MSG  = NUM_MSG_DEF,
    parameter logic [DATA_W-1:0]  END_CHAR = '0
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      send_msg,
    input  logic [$clog2(NUM_MSG)-1:0]                msg_sel,
    input  logic                                      abort,
    input  logic                                      fifo_empty,
    input  logic                                      fifo_full,
    output logic                                      rom_rd_en,
    output logic [$clog2(NUM_MSG)+$clog2(MAX_LEN)-1:0] rom_addr,
    input  logic [DATA_W-1:0]                         rom_data,
    output logic                                      fifo_wr_en,
    output logic [DATA_W-1:0]                         fifo_wr_data,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      aborted,
    output logic [$clog2(MAX_LEN):0]                  char_cnt
);

    localparam int SEL_W = $clog2(NUM_MSG);
    localparam int IDX_W = $clog2(MAX_LEN);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MAX_LEN - 1);

    seq_state_e         state_q, state_d;
    logic [SEL_W-1:0]   sel_q,   sel_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [DATA_W-1:0]  char_q,  char_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               aborted_q, aborted_d;
    logic               wr_fire;

    // A write happens only in PUSH with room in the FIFO; abort and reset both veto it immediately.
    assign wr_fire = rst_n && (state_q == S_PUSH) && !fifo_full && !abort;

    // Next-state logic: abort outranks every other event outside IDLE.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        idx_d     = idx_q;
        char_d    = char_q;
        cnt_d     = cnt_q;
        aborted_d = 1'b0;
        if (abort && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            aborted_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // A request against a non-empty FIFO is dropped, not remembered.
                    if (send_msg && fifo_empty) begin
                        state_d = S_FETCH;
                        sel_d   = msg_sel;
                        idx_d   = '0;
                        cnt_d   = '0;
                    end
                end
                S_FETCH: state_d = S_WAIT;
                S_WAIT: begin
                    char_d  = rom_data;
                    state_d = (rom_data == END_CHAR) ? S_DRAIN : S_PUSH;
                end
                S_PUSH: begin
                    if (!fifo_full) begin
                        cnt_d = cnt_q + 1'b1;
                        // The index saturates at the last slot so rom_addr never leaves the message.
                        if (idx_q == IDX_LAST) begin
                            state_d = S_DRAIN;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = S_FETCH;
                        end
                    end
                end
                S_DRAIN: begin
                    if (fifo_empty) state_d = S_DONE;
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            sel_q     <= '0;
            idx_q     <= '0;
            char_q    <= '0;
            cnt_q     <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            idx_q     <= idx_d;
            char_q    <= char_d;
            cnt_q     <= cnt_d;
            aborted_q <= aborted_d;
        end
    end

    assign rom_rd_en    = rst_n && (state_q == S_FETCH);
    assign rom_addr     = {sel_q, idx_q};
    assign fifo_wr_en   = wr_fire;
    assign fifo_wr_data = char_q;
    assign busy         = rst_n && (state_q != S_IDLE);
    assign done         = rst_n && (state_q == S_DONE);
    assign aborted      = aborted_q;
    assign char_cnt     = cnt_q;

endmodule

// File: tb/tb_msg_sequencer.sv
// Directed bench for msg_sequencer with an expected-character queue drained by a write monitor.
// Latency: n/a.
// Backpressure: the bench drives fifo_full / fifo_empty directly.
module tb_msg_sequencer;

    localparam int DATA_W  = 8;
    localparam int MAX_LEN = 32;
    localparam int NUM_MSG = 4;
    localparam int ADDR_W  = 7;

    logic              clk;
    logic              rst_n;
    logic              send_msg;
    logic [1:0]        msg_sel;
    logic              abort;
    logic              fifo_empty;
    logic              fifo_full;
    logic              rom_rd_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic              fifo_wr_en;
    logic [7:0]        fifo_wr_data;
    logic              busy;
    logic              done;
    logic              aborted;
    logic [5:0]        char_cnt;

    msg_sequencer #(
        .DATA_W  (DATA_W),
        .MAX_LEN (MAX_LEN),
        .NUM_MSG (NUM_MSG),
        .END_CHAR(8'h00)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .send_msg    (send_msg),
        .msg_sel     (msg_sel),
        .abort       (abort),
        .fifo_empty  (fifo_empty),
        .fifo_full   (fifo_full),
        .rom_rd_en   (rom_rd_en),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_wr_data(fifo_wr_data),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .char_cnt    (char_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Message ROM: 0 = 32 chars without terminator, 1 = "HI", 2 = empty, 3 = "ABC".
    logic [7:0] rom [0:127];
    initial begin
        for (int i = 0; i < 128; i++) rom[i] = 8'h00;
        for (int i = 0; i < 32; i++) rom[i] = 8'(8'h41 + i);
        rom[32] = 8'h48; rom[33] = 8'h49; rom[34] = 8'h00;
        rom[64] = 8'h00;
        rom[96] = 8'h41; rom[97] = 8'h42; rom[98] = 8'h43; rom[99] = 8'h00;
    end

    always @(posedge clk) begin
        if (!rst_n) rom_data <= 8'h00;
        else if (rom_rd_en) rom_data <= rom[rom_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_count = 0;
    int done_cnt = 0;
    int abt_cnt = 0;
    int rd_cnt = 0;
    int max_addr = 0;
    int wr_cyc[$];
    logic [7:0] exp_q[$];
    logic [7:0] mon_e;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every FIFO write must match the next expected character.
    always @(negedge clk) begin
        if (fifo_wr_en === 1'b1) begin
            wr_count++;
            wr_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got data 0x%0h, required no write", fifo_wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_data", 32'(fifo_wr_data), 32'(mon_e));
            end
        end
        if (done === 1'b1) done_cnt++;
        if (aborted === 1'b1) abt_cnt++;
        if (rom_rd_en === 1'b1) begin
            rd_cnt++;
            if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [1:0] sel);
        msg_sel  = sel;
        send_msg = 1'b1;
        tick();
        send_msg = 1'b0;
    endtask

    task automatic wait_writes(input int target, input int budget, input string name);
        int n = 0;
        while (wr_count < target && n < budget) begin
            tick();
            n++;
        end
        check(name, wr_count, target);
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(done), 1);
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_strobes"}, 32'({rom_rd_en, fifo_wr_en, busy, done, aborted}), 0);
        check({name, "_rom_addr"}, 32'(rom_addr), 0);
        check({name, "_wr_data"}, 32'(fifo_wr_data), 0);
        check({name, "_char_cnt"}, 32'(char_cnt), 0);
    endtask

    initial begin
        int base;
        int dbase;
        int rbase;
        rst_n      = 1'b0;
        send_msg   = 1'b0;
        msg_sel    = 2'd0;
        abort      = 1'b0;
        fifo_empty = 1'b1;
        fifo_full  = 1'b0;

        // Reset state, during and after reset.
        repeat (3) tick();
        check_idle_outputs("in_reset");
        rst_n = 1'b1;
        tick();
        check_idle_outputs("post_reset");

        // "HI": two writes 3 cycles apart, done only once the FIFO drains.
        base = wr_count;
        exp_q.push_back(8'h48);
        exp_q.push_back(8'h49);
        start(2'd1);
        fifo_empty = 1'b0;
        check("hi_busy", 32'(busy), 1);
        wait_writes(base + 2, 30, "hi_writes");
        check("hi_spacing", wr_cyc[wr_cyc.size()-1] - wr_cyc[wr_cyc.size()-2], 3);
        repeat (3) tick();
        check("hi_drain_hold", 32'({busy, done}), 2);
        fifo_empty = 1'b1;
        wait_done(10, "hi_done");
        check("hi_char_cnt", 32'(char_cnt), 2);
        tick();
        check("hi_done_pulse", 32'({busy, done}), 0);

        // fifo_full held over the second PUSH: no write during the stall, then exactly one.
        base = wr_count;
        exp_q.push_back(8'h48);
        exp_q.push_back(8'h49);
        start(2'd1);
        fifo_empty = 1'b0;
        wait_writes(base + 1, 30, "full_first");
        tick();
        fifo_full = 1'b1;
        repeat (6) tick();
        check("full_stall", wr_count, base + 1);
        fifo_full = 1'b0;
        tick();
        check("full_release_write", wr_count, base + 2);
        fifo_empty = 1'b1;
        wait_done(10, "full_done");
        check("full_char_cnt", 32'(char_cnt), 2);
        tick();

        // No terminator: exactly MAX_LEN writes, address saturates at {sel,31}.
        base  = wr_count;
        rbase = rd_cnt;
        max_addr = 0;
        for (int i = 0; i < 32; i++) exp_q.push_back(8'(8'h41 + i));
        start(2'd0);
        fifo_empty = 1'b0;
        wait_writes(base + 32, 200, "long_writes");
        check("long_in_drain", 32'({busy, done}), 2);
        check("long_addr_sat", 32'(rom_addr), 31);
        check("long_reads", rd_cnt - rbase, 32);
        check("long_max_addr", max_addr, 31);
        repeat (2) tick();
        check("long_no_extra", wr_count, base + 32);
        fifo_empty = 1'b1;
        wait_done(10, "long_done");
        check("long_char_cnt", 32'(char_cnt), 32);
        tick();

        // Abort in PUSH with room in the FIFO.
        base  = wr_count;
        dbase = done_cnt;
        exp_q.push_back(8'h41);
        start(2'd3);
        wait_writes(base + 1, 30, "abort_first");
        tick();
        tick();
        abort = 1'b1;
        #1;
        check("abort_no_write", 32'({busy, fifo_wr_en}), 2);
        tick();
        abort = 1'b0;
        check("abort_idle_pulse", 32'({busy, aborted}), 1);
        tick();
        check("abort_pulse_end", 32'(aborted), 0);
        check("abort_char_cnt", 32'(char_cnt), 1);
        check("abort_no_done", done_cnt, dbase);
        check("abort_writes", wr_count, base + 1);

        // Start with a non-empty FIFO is ignored; empty message completes with zero writes.
        base  = wr_count;
        rbase = rd_cnt;
        fifo_empty = 1'b0;
        msg_sel    = 2'd1;
        send_msg   = 1'b1;
        tick();
        check("ignored_busy0", 32'(busy), 0);
        tick();
        send_msg = 1'b0;
        check("ignored_busy1", 32'(busy), 0);
        check("ignored_no_read", rd_cnt, rbase);
        fifo_empty = 1'b1;
        start(2'd2);
        wait_done(10, "empty_done");
        check("empty_char_cnt", 32'(char_cnt), 0);
        check("empty_no_write", wr_count, base);
        tick();

        // Reset in mid-message drops it; a following start works normally.
        base = wr_count;
        exp_q.push_back(8'h48);
        exp_q.push_back(8'h49);
        start(2'd1);
        wait_writes(base + 1, 30, "rst_first");
        rst_n = 1'b0;
        tick();
        check_idle_outputs("mid_reset");
        exp_q.delete();
        rst_n = 1'b1;
        repeat (6) tick();
        check("rst_no_write", wr_count, base + 1);
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h43);
        start(2'd3);
        wait_writes(base + 4, 40, "rst_restart_writes");
        wait_done(10, "rst_restart_done");
        check("rst_restart_cnt", 32'(char_cnt), 3);
        tick();

        check("total_done", done_cnt, 5);
        check("total_aborted", abt_cnt, 1);
        check("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
